uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
Message-level initiator for the UART transmitter. It latches a 4-byte message on a start request and feeds it byte by byte through the transmitter's Tx_WR/Tx_BUSY write handshake, MSB byte first. It enforces a programmable inter-byte gap and detects a transmitter that never acknowledges a write. It sits on the clk1 (transmit) domain in front of the transmitter; the receive path (receiver, register, LED driver) then displays the bytes it sends.

Parameters:
GAP_CYCLES, 16, idle clk cycles inserted after Tx_BUSY falls before the next Tx_WR (min 1)
ACK_TIMEOUT, 8, clk cycles allowed after Tx_WR for Tx_BUSY to rise before aborting (min 2)

Ports:
clk  input  1  transmit-domain clock (clk1 at system level)
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
msg_data  input  32  message; byte3 = [31:24] sent first, byte0 = [7:0] last
Tx_BUSY  input  1  transmitter busy flag
Tx_DATA  output  8  byte presented to the transmitter
Tx_WR  output  1  one-cycle write strobe to the transmitter
Tx_EN  output  1  transmitter enable; high for the whole session
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle pulse: message completed without error
error  output  1  sticky ACK-timeout flag; cleared by the next accepted start or by reset

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE. Tx_DATA=8'h00; Tx_WR, Tx_EN, busy, done, error all 0. Byte index=3; counters=0.
- All outputs are registered.
- IDLE:
  - start=1 latches msg_data into a shift register and sets byte index=3.
  - It clears error and sets busy=1 and Tx_EN=1 on the next edge.
  - Next state is ARM.
- ARM: wait until Tx_BUSY=0.
  - Then drive Tx_DATA = current byte and Tx_WR=1 for exactly one cycle.
  - Next state is WAIT_HI; the ACK counter is cleared.
  - Tx_DATA holds its value until the next byte is loaded.
- WAIT_HI:
  - Tx_BUSY=1 moves to WAIT_LO.
  - If the counter reaches ACK_TIMEOUT-1 without Tx_BUSY=1: set error=1, clear busy and Tx_EN, no done pulse, go to IDLE.
- WAIT_LO: on Tx_BUSY=0, clear the gap counter.
  - If byte index=0, go to FINISH.
  - Otherwise decrement byte index and go to GAP.
  - There is no timeout here; byte duration depends on baud_select.
- GAP: count GAP_CYCLES cycles, then go to ARM.
- FINISH: done=1 for one cycle; busy=0 and Tx_EN=0 on the same edge; go to IDLE.
- Tx_WR must never be asserted while Tx_BUSY=1, and is never asserted twice for one byte.
- start while busy=1 is ignored. It is not queued, and msg_data changes mid-session have no effect.
- start in the FINISH cycle is ignored. start in the first IDLE cycle after FINISH is accepted.
- Reset asserted mid-byte returns to the reset values immediately. No partial completion is signalled.
- Counter widths are sized with $clog2(param+1). Wrap-around is never reached because the counters clear on every state entry.

Decomposition:
- Shared package uart_tx_seq_pkg:
  - State encoding: IDLE, ARM, WAIT_HI, WAIT_LO, GAP, FINISH.
  - Constant MSG_BYTES=4.
  - Byte-index width.
- Sub-module: none is required. The gap/timeout down-counter may be factored into seq_counter (load, decrement, zero flag) shared by GAP and WAIT_HI.

Test Plan:
- Nominal: msg_data=32'hA53C0FF0, start pulse, transmitter model busy 1 cycle after Tx_WR for 20 cycles.
  - Expect Tx_WR pulses with Tx_DATA A5, 3C, 0F, F0 in order.
  - Expect ≥GAP_CYCLES idle cycles between each Tx_BUSY fall and the next Tx_WR.
  - Expect exactly one done pulse, error=0, and busy high from the cycle after start until the done cycle.
- Backpressure: Tx_BUSY held 1 when start arrives, released 30 cycles later.
  - First Tx_WR appears only after the release; never while Tx_BUSY=1.
- ACK timeout: model never raises Tx_BUSY.
  - Exactly one Tx_WR with Tx_DATA=A5; error=1 ACK_TIMEOUT cycles later; busy=0, Tx_EN=0, no done.
  - A following start with msg_data=32'h01020304 clears error and completes normally.
- Ignored start: second start with msg_data=32'hFFFFFFFF during byte 2.
  - Output sequence is still A5, 3C, 0F, F0; only one done pulse.
- Reset mid-operation: assert reset during WAIT_LO of byte 1.
  - All outputs go to their reset values asynchronously.
  - After release, no Tx_WR until a new start; a new start transmits a full 4-byte message.
- Back-to-back: start in the FINISH cycle is ignored; start one cycle later begins a new message with the correct first byte.

Source files
------------

// File: rtl/uart_tx_seq_pkg.sv
// Shared types and constants for the UART message sequencer.
// A message is MSG_BYTES bytes, sent from the most significant byte down.
package uart_tx_seq_pkg;

   localparam int MSG_BYTES = 4;
   localparam int IDX_W     = $clog2(MSG_BYTES);

   typedef logic [IDX_W-1:0] byte_idx_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      GAP     = 3'd4,
      FINISH  = 3'd5
   } seq_state_t;

   function automatic logic [7:0] msg_byte(input logic [8*MSG_BYTES-1:0] msg,
                                           input byte_idx_t idx);
      return msg[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_sequencer_counter.sv
// Loadable down-counter shared by the ACK timeout and the inter-byte gap.
// Saturates at zero; zero flag is the terminal-count compare.
module seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// Message-level initiator: latches a 4-byte message and writes it byte by
// byte into the UART transmitter through the Tx_WR/Tx_BUSY handshake.
//
// state   | meaning
// IDLE    | waiting for start; outputs quiescent
// ARM     | waiting for Tx_BUSY=0 before writing the current byte
// WAIT_HI | Tx_WR issued; waiting for the transmitter to raise Tx_BUSY
// WAIT_LO | transmitter shifting the byte out; waiting for Tx_BUSY=0
// GAP     | enforced idle time between bytes
// FINISH  | done pulse visible; returns to IDLE
module uart_tx_sequencer
   import uart_tx_seq_pkg::*;
#(
   parameter int GAP_CYCLES  = 16,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] msg_data,
   input  logic        Tx_BUSY,
   output logic [7:0]  Tx_DATA,
   output logic        Tx_WR,
   output logic        Tx_EN,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int CNT_W = (GAP_W > ACK_W) ? GAP_W : ACK_W;

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

   seq_state_t state_q, state_d;
   logic [31:0] msg_q, msg_d;
   byte_idx_t   idx_q, idx_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_wr_q, tx_wr_d;
   logic        tx_en_q, tx_en_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_zero;

   seq_counter #(
      .WIDTH (CNT_W)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_load_val),
      .dec        (cnt_dec),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         msg_q     <= '0;
         idx_q     <= byte_idx_t'(MSG_BYTES - 1);
         tx_data_q <= 8'h00;
         tx_wr_q   <= 1'b0;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         msg_q     <= msg_d;
         idx_q     <= idx_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         tx_en_q   <= tx_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      msg_d        = msg_q;
      idx_d        = idx_q;
      tx_data_d    = tx_data_q;
      tx_wr_d      = 1'b0;
      tx_en_d      = tx_en_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = error_q;
      cnt_load     = 1'b0;
      cnt_load_val = GAP_LOAD;
      cnt_dec      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               msg_d   = msg_data;
               idx_d   = byte_idx_t'(MSG_BYTES - 1);
               error_d = 1'b0;
               busy_d  = 1'b1;
               tx_en_d = 1'b1;
               state_d = ARM;
            end
         end
         ARM: begin
            if (!Tx_BUSY) begin
               tx_data_d    = msg_byte(msg_q, idx_q);
               tx_wr_d      = 1'b1;
               cnt_load     = 1'b1;
               cnt_load_val = ACK_LOAD;
               state_d      = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (Tx_BUSY) begin
               state_d = WAIT_LO;
            end else if (cnt_zero) begin
               // transmitter never acknowledged: abort without a done pulse
               error_d = 1'b1;
               busy_d  = 1'b0;
               tx_en_d = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!Tx_BUSY) begin
               cnt_load     = 1'b1;
               cnt_load_val = GAP_LOAD;
               if (idx_q == '0) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  tx_en_d = 1'b0;
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q - byte_idx_t'(1);
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_d = ARM;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Tx_DATA = tx_data_q;
   assign Tx_WR   = tx_wr_q;
   assign Tx_EN   = tx_en_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a simple transmitter model that
// raises Tx_BUSY one cycle after each write and holds it for BUSY_LEN cycles.
module tb_uart_tx_sequencer;

   localparam int GAP      = 16;
   localparam int ACK      = 8;
   localparam int BUSY_LEN = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] msg_data = '0;
   logic        tx_busy = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_en;
   logic        busy;
   logic        done;
   logic        error;

   always #5 clk = ~clk;

   uart_tx_sequencer #(
      .GAP_CYCLES  (GAP),
      .ACK_TIMEOUT (ACK)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .msg_data (msg_data),
      .Tx_BUSY  (tx_busy),
      .Tx_DATA  (tx_data),
      .Tx_WR    (tx_wr),
      .Tx_EN    (tx_en),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   int checks = 0;
   int errors = 0;

   bit   model_ack = 1'b1;
   bit   force_busy = 1'b0;
   int   busy_left = 0;
   logic [7:0] wr_log[$];
   int   gap_log[$];
   int   wr_viol = 0;
   int   done_cnt = 0;
   int   gap_run = 0;
   bit   fell = 1'b0;
   bit   prev_busy = 1'b0;

   // monitor plus transmitter model, all on the falling edge
   always @(negedge clk) begin
      if (tx_wr) begin
         wr_log.push_back(tx_data);
         if (tx_busy) wr_viol++;
         if (fell) gap_log.push_back(gap_run);
         fell = 1'b0;
      end
      if (done) done_cnt++;
      if (prev_busy && !tx_busy) begin
         fell    = 1'b1;
         gap_run = 0;
      end
      if (!tx_busy && !tx_wr) gap_run++;
      prev_busy = tx_busy;

      if (force_busy) begin
         tx_busy = 1'b1;
      end else if (model_ack && busy_left > 0) begin
         tx_busy = 1'b1;
         busy_left--;
      end else begin
         tx_busy = 1'b0;
      end
      if (tx_wr && model_ack && !force_busy) busy_left = BUSY_LEN;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [31:0] m);
      msg_data = m;
      start    = 1'b1;
      step(1);
      start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int  n = 0;
      bit  dropped = 1'b0;
      while (!done && n < budget) begin
         if (!busy) dropped = 1'b1;
         step(1);
         n++;
      end
      chk({tag, " done seen"}, 32'(done), 32'd1);
      chk({tag, " busy held"}, 32'(dropped), 32'd0);
      chk({tag, " busy/en low at done"}, {30'd0, busy, tx_en}, 32'd0);
   endtask

   task automatic wait_wr(input string tag, input int budget);
      int n = 0;
      while (!tx_wr && n < budget) begin
         step(1);
         n++;
      end
      chk({tag, " wr seen"}, 32'(tx_wr), 32'd1);
   endtask

   task automatic chk_msg(input string tag, input int base, input logic [31:0] exp);
      logic [7:0] got;
      logic [7:0] want;
      for (int i = 0; i < 4; i++) begin
         got  = (base + i < wr_log.size()) ? wr_log[base + i] : 8'hxx;
         want = exp[31 - 8*i -: 8];
         chk($sformatf("%s byte%0d", tag, i), 32'(got), 32'(want));
      end
   endtask

   initial begin
      int base;
      int base2;
      int dbase;
      int gbase;
      int min_gap;
      int n;

      #12;
      chk("reset outputs", {18'd0, tx_data, tx_wr, tx_en, busy, done, error}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(2);

      // nominal message
      base  = wr_log.size();
      dbase = done_cnt;
      gbase = gap_log.size();
      pulse_start(32'hA53C0FF0);
      chk("nom busy/en after start", {30'd0, busy, tx_en}, 32'd3);
      wait_done("nom", 500);
      chk("nom error", 32'(error), 32'd0);
      step(2);
      chk("nom wr count", 32'(wr_log.size() - base), 32'd4);
      chk("nom done count", 32'(done_cnt - dbase), 32'd1);
      chk_msg("nom", base, 32'hA53C0FF0);
      chk("nom gap count", 32'(gap_log.size() - gbase), 32'd3);
      min_gap = 1000;
      for (int i = gbase; i < gap_log.size(); i++)
         if (gap_log[i] < min_gap) min_gap = gap_log[i];
      chk("nom min gap ok", 32'(min_gap >= GAP), 32'd1);

      // backpressure: transmitter busy when start arrives
      force_busy = 1'b1;
      step(2);
      base = wr_log.size();
      pulse_start(32'hDEADBEEF);
      step(29);
      chk("bp no wr while held", 32'(wr_log.size() - base), 32'd0);
      force_busy = 1'b0;
      wait_done("bp", 500);
      chk("bp wr count", 32'(wr_log.size() - base), 32'd4);
      chk_msg("bp", base, 32'hDEADBEEF);

      // ACK timeout: transmitter never raises Tx_BUSY
      model_ack = 1'b0;
      step(2);
      base  = wr_log.size();
      dbase = done_cnt;
      pulse_start(32'hA53C0FF0);
      wait_wr("to", 50);
      chk("to first byte", 32'(tx_data), 32'hA5);
      step(ACK - 1);
      chk("to error not yet", 32'(error), 32'd0);
      step(1);
      chk("to error set", 32'(error), 32'd1);
      chk("to busy/en low", {30'd0, busy, tx_en}, 32'd0);
      step(5);
      chk("to wr count", 32'(wr_log.size() - base), 32'd1);
      chk("to no done", 32'(done_cnt - dbase), 32'd0);
      chk("to error sticky", 32'(error), 32'd1);
      model_ack = 1'b1;
      base = wr_log.size();
      pulse_start(32'h01020304);
      chk("rec error cleared", 32'(error), 32'd0);
      wait_done("rec", 500);
      chk("rec wr count", 32'(wr_log.size() - base), 32'd4);
      chk_msg("rec", base, 32'h01020304);

      // ignored start during the second byte
      step(2);
      base  = wr_log.size();
      dbase = done_cnt;
      pulse_start(32'hA53C0FF0);
      wait_wr("ign wr1", 100);
      step(1);
      wait_wr("ign wr2", 100);
      step(3);
      pulse_start(32'hFFFFFFFF);
      chk("ign busy", 32'(busy), 32'd1);
      wait_done("ign", 500);
      step(2);
      chk("ign wr count", 32'(wr_log.size() - base), 32'd4);
      chk("ign done count", 32'(done_cnt - dbase), 32'd1);
      chk_msg("ign", base, 32'hA53C0FF0);

      // reset while the first byte is being shifted out
      step(2);
      dbase = done_cnt;
      pulse_start(32'hA53C0FF0);
      wait_wr("rst wr", 100);
      n = 0;
      while (!tx_busy && n < 10) begin
         step(1);
         n++;
      end
      chk("rst in byte", 32'(tx_busy), 32'd1);
      step(3);
      #2;
      reset = 1'b0;
      #1;
      chk("rst async outputs", {18'd0, tx_data, tx_wr, tx_en, busy, done, error}, 32'd0);
      base2 = wr_log.size();
      step(2);
      reset = 1'b1;
      step(40);
      chk("rst no wr after", 32'(wr_log.size() - base2), 32'd0);
      chk("rst no done", 32'(done_cnt - dbase), 32'd0);
      pulse_start(32'h5A6B7C8D);
      wait_done("rst new", 500);
      chk("rst new wr count", 32'(wr_log.size() - base2), 32'd4);
      chk_msg("rst new", base2, 32'h5A6B7C8D);

      // back-to-back: start in FINISH ignored, start one cycle later accepted
      step(2);
      base  = wr_log.size();
      dbase = done_cnt;
      pulse_start(32'h0F1E2D3C);
      wait_done("b2b first", 500);
      msg_data = 32'h11111111;
      start    = 1'b1;
      step(1);
      chk("b2b finish start ignored", 32'(busy), 32'd0);
      msg_data = 32'hC3D2E1F0;
      step(1);
      start    = 1'b0;
      chk("b2b idle start accepted", 32'(busy), 32'd1);
      base2 = wr_log.size();
      wait_done("b2b second", 500);
      step(2);
      chk("b2b wr count", 32'(wr_log.size() - base), 32'd8);
      chk("b2b done count", 32'(done_cnt - dbase), 32'd2);
      chk_msg("b2b first", base, 32'h0F1E2D3C);
      chk_msg("b2b second", base2, 32'hC3D2E1F0);

      chk("no wr while tx busy", 32'(wr_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
